// File: rtl/inst_fetch_decoder.sv
// inst_fetch_decoder
// Buffers bus words in a DEPTH-entry prefetch queue. A sequencer pops the
// opcode and up to two argument words, then presents one assembled micro-op
// on a valid/ready handshake. Fetch and issue are decoupled; i_flush drops
// everything queued or partially assembled (used on jumps).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_word          fetched bus word, qualified by i_word_valid
//   o_word_ready    queue can accept a word (not full)
//   i_flush         discard queue and any partial/pending instruction
//   o_uop_valid     micro-op fields valid, held until i_uop_ready
//   i_uop_ready     consumer accepts the micro-op
//   o_opcode        opcode word
//   o_arg0, o_arg1  argument words (0 when unused)
//   o_argc          number of argument words consumed (0-2)
//   o_wb            write-back required (MOV_RA)
//   o_illegal       opcode not in table (trap build only)
//   o_level         queue occupancy
//
// Build option: define ILLEGAL_TRAP_EN to issue illegal opcodes as a
// micro-op with o_illegal=1 and then halt until flush or reset. Without it,
// illegal opcodes are silently dropped.
module inst_fetch_decoder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  input  logic              i_flush,
  output logic              o_uop_valid,
  input  logic              i_uop_ready,
  output logic [DATA_W-1:0] o_opcode,
  output logic [DATA_W-1:0] o_arg0,
  output logic [DATA_W-1:0] o_arg1,
  output logic [1:0]        o_argc,
  output logic              o_wb,
  output logic              o_illegal,
  output logic [LVL_W-1:0]  o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [2:0] {OPC, ARG0, ARG1, ISSUE, HALT} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic [1:0]        lut_argc;
  logic              lut_wb;
  logic              lut_illegal;
  logic              uop_valid_q;
  logic [DATA_W-1:0] opcode_q;
  logic [DATA_W-1:0] arg0_q;
  logic [DATA_W-1:0] arg1_q;
  logic [1:0]        argc_q;
  logic              wb_q;

  assign o_word_ready = (level != FULL_LVL);
  // Flush overrides both sides of the queue in the same cycle.
  assign push = i_word_valid && o_word_ready && !i_flush;
  assign pop  = !i_flush && (level != '0) &&
                ((state == OPC) || (state == ARG0) || (state == ARG1));
  assign head = mem[rd_ptr];

  assign o_level     = level;
  assign o_uop_valid = uop_valid_q;
  assign o_opcode    = opcode_q;
  assign o_arg0      = arg0_q;
  assign o_arg1      = arg1_q;
  assign o_argc      = argc_q;
  assign o_wb        = wb_q;

  // Opcode table lookup on the queue head; full-word compare.
  always_comb begin
    lut_argc    = 2'd0;
    lut_wb      = 1'b0;
    lut_illegal = 1'b0;
    case (head)
      DATA_W'(0): lut_argc = 2'd0;
      DATA_W'(1): lut_argc = 2'd2;
      DATA_W'(2): lut_argc = 2'd2;
      DATA_W'(3): begin
        lut_argc = 2'd2;
        lut_wb   = 1'b1;
      end
      DATA_W'(4): lut_argc = 2'd2;
      DATA_W'(5): lut_argc = 2'd1;
      default:    lut_illegal = 1'b1;
    endcase
  end

  // Storage has no reset; occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_word;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign o_illegal = illegal_q;
`else
  assign o_illegal = 1'b0;
`endif

  // Sequencer: assembles opcode + args, then holds the micro-op until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_flush) begin
      state       <= OPC;
      uop_valid_q <= 1'b0;
      opcode_q    <= '0;
      arg0_q      <= '0;
      arg1_q      <= '0;
      argc_q      <= 2'd0;
      wb_q        <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      case (state)
        OPC: if (pop) begin
          if (lut_illegal) begin
`ifdef ILLEGAL_TRAP_EN
            opcode_q    <= head;
            arg0_q      <= '0;
            arg1_q      <= '0;
            argc_q      <= 2'd0;
            wb_q        <= 1'b0;
            illegal_q   <= 1'b1;
            uop_valid_q <= 1'b1;
            state       <= ISSUE;
`endif
          end else begin
            opcode_q <= head;
            arg0_q   <= '0;
            arg1_q   <= '0;
            argc_q   <= lut_argc;
            wb_q     <= lut_wb;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
            if (lut_argc == 2'd0) begin
              uop_valid_q <= 1'b1;
              state       <= ISSUE;
            end else begin
              state <= ARG0;
            end
          end
        end
        ARG0: if (pop) begin
          arg0_q <= head;
          if (argc_q == 2'd1) begin
            uop_valid_q <= 1'b1;
            state       <= ISSUE;
          end else begin
            state <= ARG1;
          end
        end
        ARG1: if (pop) begin
          arg1_q      <= head;
          uop_valid_q <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: if (i_uop_ready) begin
          uop_valid_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
          state <= illegal_q ? HALT : OPC;
`else
          state <= OPC;
`endif
        end
        HALT: begin
`ifdef ILLEGAL_TRAP_EN
          state <= HALT;
`else
          state <= OPC;
`endif
        end
        default: state <= OPC;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_decoder.sv
// tb_inst_fetch_decoder
// Directed bench for inst_fetch_decoder (DATA_W=16, DEPTH=4): a table of
// per-cycle vectors for back-to-back ADD/JMP/NOP issue, then hand-written
// sequences for backpressure, flush in ARG1, illegal opcode handling and
// asynchronous reset during issue.
module tb_inst_fetch_decoder;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] i_word;
  logic              i_word_valid;
  logic              o_word_ready;
  logic              i_flush;
  logic              o_uop_valid;
  logic              i_uop_ready;
  logic [DATA_W-1:0] o_opcode;
  logic [DATA_W-1:0] o_arg0;
  logic [DATA_W-1:0] o_arg1;
  logic [1:0]        o_argc;
  logic              o_wb;
  logic              o_illegal;
  logic [LVL_W-1:0]  o_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_decoder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst(rst), .i_word(i_word), .i_word_valid(i_word_valid),
    .o_word_ready(o_word_ready), .i_flush(i_flush), .o_uop_valid(o_uop_valid),
    .i_uop_ready(i_uop_ready), .o_opcode(o_opcode), .o_arg0(o_arg0),
    .o_arg1(o_arg1), .o_argc(o_argc), .o_wb(o_wb), .o_illegal(o_illegal),
    .o_level(o_level)
  );

  typedef struct packed {
    logic        word_valid;
    logic [15:0] word;
    logic        flush;
    logic        uop_ready;
  } in_t;

  typedef struct packed {
    logic        uop_valid;
    logic [15:0] opcode;
    logic [15:0] arg0;
    logic [15:0] arg1;
    logic [1:0]  argc;
    logic        wb;
    logic        illegal;
    logic [2:0]  level;
    logic        word_ready;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  vec_t vecs [12];

  function automatic in_t mi(logic v, logic [15:0] w, logic r);
    in_t s;
    s.word_valid = v;
    s.word       = w;
    s.flush      = 1'b0;
    s.uop_ready  = r;
    return s;
  endfunction

  function automatic out_t mk(logic v, logic [15:0] op, logic [15:0] a0,
                              logic [15:0] a1, logic [1:0] c, logic wb,
                              logic [2:0] lvl);
    out_t o;
    o.uop_valid  = v;
    o.opcode     = op;
    o.arg0       = a0;
    o.arg1       = a1;
    o.argc       = c;
    o.wb         = wb;
    o.illegal    = 1'b0;
    o.level      = lvl;
    o.word_ready = (lvl != 3'd4);
    return o;
  endfunction

  task automatic applyStimulus(input in_t s);
    i_word_valid = s.word_valid;
    i_word       = s.word;
    i_flush      = s.flush;
    i_uop_ready  = s.uop_ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t act;
    act = '{o_uop_valid, o_opcode, o_arg0, o_arg1, o_argc, o_wb, o_illegal,
            o_level, o_word_ready};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (valid,op,a0,a1,argc,wb,ill,lvl,rdy)",
               name, act, exp);
    end
  endtask

  task automatic checkVal(input string name, input logic [63:0] act,
                          input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reset is released 1 time unit after a rising edge; that cycle is cycle 0.
  task automatic doReset();
    rst = 1'b1;
    applyStimulus(mi(1'b0, 16'h0000, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitValid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_uop_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [15:0] bp_words [8];
  logic [49:0] bp_exp   [3];

  initial begin
    bit ok;
    int idx;
    bit acc;
    bit stable;
    int seen;
    logic [15:0] first_op;
    logic        first_ill;

    // ADD 4,1,2 back to back, then JMP 00A0 and NOP; consumer always ready.
    vecs[0]  = '{mi(1, 16'h0004, 1), mk(0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 3'd0)};
    vecs[1]  = '{mi(1, 16'h0001, 1), mk(0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 3'd1)};
    vecs[2]  = '{mi(1, 16'h0002, 1), mk(0, 16'h0004, 16'h0000, 16'h0000, 2'd2, 0, 3'd1)};
    vecs[3]  = '{mi(0, 16'h0000, 1), mk(0, 16'h0004, 16'h0001, 16'h0000, 2'd2, 0, 3'd1)};
    vecs[4]  = '{mi(0, 16'h0000, 1), mk(1, 16'h0004, 16'h0001, 16'h0002, 2'd2, 0, 3'd0)};
    vecs[5]  = '{mi(1, 16'h0005, 1), mk(0, 16'h0004, 16'h0001, 16'h0002, 2'd2, 0, 3'd0)};
    vecs[6]  = '{mi(1, 16'h00A0, 1), mk(0, 16'h0004, 16'h0001, 16'h0002, 2'd2, 0, 3'd1)};
    vecs[7]  = '{mi(1, 16'h0000, 1), mk(0, 16'h0005, 16'h0000, 16'h0000, 2'd1, 0, 3'd1)};
    vecs[8]  = '{mi(0, 16'h0000, 1), mk(1, 16'h0005, 16'h00A0, 16'h0000, 2'd1, 0, 3'd1)};
    vecs[9]  = '{mi(0, 16'h0000, 1), mk(0, 16'h0005, 16'h00A0, 16'h0000, 2'd1, 0, 3'd1)};
    vecs[10] = '{mi(0, 16'h0000, 1), mk(1, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 3'd0)};
    vecs[11] = '{mi(0, 16'h0000, 1), mk(0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 3'd0)};

    bp_words = '{16'h0004, 16'h0011, 16'h0012, 16'h0001, 16'h0021, 16'h0022,
                 16'h0005, 16'h0031};
    bp_exp   = '{{16'h0004, 16'h0011, 16'h0012, 2'd2},
                 {16'h0001, 16'h0021, 16'h0022, 2'd2},
                 {16'h0005, 16'h0031, 16'h0000, 2'd1}};

    $display("[TB] vector table");
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].in);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      step();
    end

    // Backpressure: consumer stalled for 20 cycles while 8 words stream in.
    $display("[TB] backpressure");
    doReset();
    idx = 0; acc = 1'b0; stable = 1'b1; seen = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (acc) idx++;
      i_word_valid = (idx < 8);
      i_word       = (idx < 8) ? bp_words[idx] : 16'h0000;
      i_uop_ready  = (cyc >= 20);
      #1;
      acc = i_word_valid && o_word_ready;
      if (o_uop_valid && !i_uop_ready &&
          ({o_opcode, o_arg0, o_arg1, o_argc} != bp_exp[0]))
        stable = 1'b0;
      if (cyc == 19) begin
        checkVal("bp_hold_valid", 64'(o_uop_valid), 64'd1);
        checkVal("bp_full_level", 64'(o_level), 64'd4);
        checkVal("bp_full_ready", 64'(o_word_ready), 64'd0);
      end
      if (o_uop_valid && i_uop_ready) begin
        if (seen < 3)
          checkVal($sformatf("bp_uop%0d", seen),
                   64'({o_opcode, o_arg0, o_arg1, o_argc}), 64'(bp_exp[seen]));
        seen++;
      end
      step();
    end
    checkVal("bp_uop_count", 64'(seen), 64'd3);
    checkVal("bp_stable", 64'(stable), 64'd1);
    checkVal("bp_drained", 64'(o_level), 64'd0);

    // Flush while MOV_RA sits in ARG1 with two words still queued.
    $display("[TB] flush in ARG1");
    doReset();
    applyStimulus(mi(1, 16'h0000, 0)); step();
    applyStimulus(mi(1, 16'h0003, 0)); step();
    applyStimulus(mi(1, 16'h0001, 0)); step();
    applyStimulus(mi(1, 16'hAAAA, 0)); step();
    applyStimulus(mi(1, 16'hBBBB, 0)); step();
    applyStimulus(mi(0, 16'h0000, 1));
    #1;
    checkVal("fl_full_level", 64'(o_level), 64'd4);
    checkVal("fl_full_ready", 64'(o_word_ready), 64'd0);
    step();
    step();
    step();
    #1;
    checkVal("fl_arg1_ctx", 64'({o_opcode, o_arg0, o_level, o_uop_valid}),
             64'({16'h0003, 16'h0001, 3'd2, 1'b0}));
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    #1;
    checkOutput("fl_after", mk(0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 3'd0));
    applyStimulus(mi(1, 16'h0003, 1)); step();
    applyStimulus(mi(1, 16'h0001, 1)); step();
    applyStimulus(mi(1, 16'h0002, 1)); step();
    applyStimulus(mi(0, 16'h0000, 1));
    waitValid(10, ok);
    checkVal("fl_movra_timeout", 64'(ok), 64'd1);
    #1;
    checkOutput("fl_movra", mk(1, 16'h0003, 16'h0001, 16'h0002, 2'd2, 1, 3'd0));
    step();

    // Illegal opcode followed by NOP.
    $display("[TB] illegal opcode");
    doReset();
    seen = 0; first_op = 16'hDEAD; first_ill = 1'bx;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc == 0)      applyStimulus(mi(1, 16'h00FF, 1));
      else if (cyc == 1) applyStimulus(mi(1, 16'h0000, 1));
      else               applyStimulus(mi(0, 16'h0000, 1));
      #1;
      if (o_uop_valid) begin
        if (seen == 0) begin
          first_op  = o_opcode;
          first_ill = o_illegal;
        end
        seen++;
      end
      step();
    end
    checkVal("ill_uop_count", 64'(seen), 64'd1);
`ifdef ILLEGAL_TRAP_EN
    checkVal("ill_first_op", 64'(first_op), 64'h00FF);
    checkVal("ill_first_flag", 64'(first_ill), 64'd1);
    checkVal("ill_halt_level", 64'(o_level), 64'd1);
`else
    checkVal("ill_first_op", 64'(first_op), 64'h0000);
    checkVal("ill_first_flag", 64'(first_ill), 64'd0);
    checkVal("ill_drop_level", 64'(o_level), 64'd0);
`endif

    // Asynchronous reset while a JMP micro-op is being held.
    $display("[TB] async reset in ISSUE");
    doReset();
    applyStimulus(mi(1, 16'h0005, 0)); step();
    applyStimulus(mi(1, 16'h00A0, 0)); step();
    applyStimulus(mi(0, 16'h0000, 0));
    waitValid(10, ok);
    checkVal("ar_issue_timeout", 64'(ok), 64'd1);
    #1;
    checkOutput("ar_issue", mk(1, 16'h0005, 16'h00A0, 16'h0000, 2'd1, 0, 3'd0));
    #1;
    rst = 1'b1;
    #1;
    checkOutput("ar_reset", mk(0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 3'd0));
    step();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
